// File: rtl/alu_pkg.sv
// Shared constants and result bundle for the 32-bit MIPS-style ALU.
package alu_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned CTRL_W  = 4;
    localparam int unsigned CHUNK_W = 8;

    localparam logic [CTRL_W-1:0] ALU_AND  = 4'b0000;
    localparam logic [CTRL_W-1:0] ALU_OR   = 4'b0001;
    localparam logic [CTRL_W-1:0] ALU_ADD  = 4'b0010;
    localparam logic [CTRL_W-1:0] ALU_SUB  = 4'b0110;
    localparam logic [CTRL_W-1:0] ALU_SLT  = 4'b0111;
    localparam logic [CTRL_W-1:0] ALU_XNOR = 4'b1100;

    typedef struct packed {
        logic [DATA_W-1:0] res;
        logic              zero;
        logic              carry_out;
        logic              overflow;
    } alu_result_t;

endpackage

// File: rtl/alu_adder_8.sv
// 8-bit ripple-carry adder slice; also exposes the carry into its top bit
// so the slice holding bit 31 can supply the overflow term.
module alu_adder_8
    import alu_pkg::*;
(
    input  logic [CHUNK_W-1:0] i_a,
    input  logic [CHUNK_W-1:0] i_b,
    input  logic               i_cin,
    output logic [CHUNK_W-1:0] o_sum_c,
    output logic               o_cout_c,
    output logic               o_c7_c
);

    always_comb begin
        logic carry;
        carry    = i_cin;
        o_sum_c  = '0;
        o_c7_c   = 1'b0;
        for (int i = 0; i < int'(CHUNK_W); i++) begin
            o_sum_c[i] = i_a[i] ^ i_b[i] ^ carry;
            if (i == int'(CHUNK_W) - 1) begin
                o_c7_c = carry;
            end
            carry = (i_a[i] & i_b[i]) | (carry & (i_a[i] ^ i_b[i]));
        end
        o_cout_c = carry;
    end

endmodule

// File: rtl/alu_32.sv
// 32-bit ALU (AND/OR/ADD/SUB/SLT/XNOR) with registered result and flags.
// ADD, SUB and SLT share one chained ripple adder.
module alu_32
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [CTRL_W-1:0] alu_ctrl,
    output logic [DATA_W-1:0] res,
    output logic              zero,
    output logic              carry_out,
    output logic              overflow
);

    logic              w_sub;
    logic [DATA_W-1:0] w_b_eff;
    logic [DATA_W-1:0] w_sum;
    logic              w_c8, w_c16, w_c24, w_c32, w_c31;
    logic              w_unused_c7_0, w_unused_c7_1, w_unused_c7_2;
    logic              w_ovf;
    logic              w_less;
    alu_result_t       w_next;

    logic [DATA_W-1:0] r_res;
    logic              r_zero;
    logic              r_carry_out;
    logic              r_overflow;

    // SUB and SLT compute a + ~b + 1
    assign w_sub   = (alu_ctrl == ALU_SUB) || (alu_ctrl == ALU_SLT);
    assign w_b_eff = w_sub ? ~b : b;

    alu_adder_8 u_add0 (
        .i_a(a[7:0]),   .i_b(w_b_eff[7:0]),   .i_cin(w_sub),
        .o_sum_c(w_sum[7:0]),   .o_cout_c(w_c8),  .o_c7_c(w_unused_c7_0)
    );
    alu_adder_8 u_add1 (
        .i_a(a[15:8]),  .i_b(w_b_eff[15:8]),  .i_cin(w_c8),
        .o_sum_c(w_sum[15:8]),  .o_cout_c(w_c16), .o_c7_c(w_unused_c7_1)
    );
    alu_adder_8 u_add2 (
        .i_a(a[23:16]), .i_b(w_b_eff[23:16]), .i_cin(w_c16),
        .o_sum_c(w_sum[23:16]), .o_cout_c(w_c24), .o_c7_c(w_unused_c7_2)
    );
    alu_adder_8 u_add3 (
        .i_a(a[31:24]), .i_b(w_b_eff[31:24]), .i_cin(w_c24),
        .o_sum_c(w_sum[31:24]), .o_cout_c(w_c32), .o_c7_c(w_c31)
    );

    // Signed overflow from carries around bit 31; SLT corrects the sign with it
    assign w_ovf  = w_c31 ^ w_c32;
    assign w_less = w_sum[DATA_W-1] ^ w_ovf;

    always_comb begin
        w_next = '0;
        case (alu_ctrl)
            ALU_AND:  w_next.res = a & b;
            ALU_OR:   w_next.res = a | b;
            ALU_XNOR: w_next.res = ~(a ^ b);
            ALU_ADD, ALU_SUB: begin
                w_next.res       = w_sum;
                w_next.carry_out = w_c32;
                w_next.overflow  = w_ovf;
            end
            ALU_SLT:  w_next.res = DATA_W'(w_less);
            default:  w_next.res = '0;
        endcase
        w_next.zero = (w_next.res == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res       <= '0;
            r_zero      <= 1'b1;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_res       <= w_next.res;
            r_zero      <= w_next.zero;
            r_carry_out <= w_next.carry_out;
            r_overflow  <= w_next.overflow;
        end
    end

    assign res       = r_res;
    assign zero      = r_zero;
    assign carry_out = r_carry_out;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_alu_32.sv
// Self-checking bench for alu_32: expected results are queued when operands
// are driven and popped when the registered outputs are sampled.
module tb_alu_32;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_XNOR = 4'b1100;

    typedef struct packed {
        logic [31:0] res;
        logic        zero;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  alu_ctrl;
    logic [31:0] res;
    logic        zero;
    logic        carry_out;
    logic        overflow;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    alu_32 dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .alu_ctrl(alu_ctrl),
        .res(res), .zero(zero), .carry_out(carry_out), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference behaviour written from the arithmetic definitions
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv);
        exp_t        e;
        logic [32:0] s;
        e = '0;
        case (op)
            OP_AND:  e.res = av & bv;
            OP_OR:   e.res = av | bv;
            OP_XNOR: e.res = ~(av ^ bv);
            OP_ADD: begin
                s      = {1'b0, av} + {1'b0, bv};
                e.res  = s[31:0];
                e.cout = s[32];
                e.ovf  = (av[31] == bv[31]) && (e.res[31] != av[31]);
            end
            OP_SUB: begin
                e.res  = av - bv;
                e.cout = (av >= bv);
                e.ovf  = (av[31] != bv[31]) && (e.res[31] != av[31]);
            end
            OP_SLT:  e.res = ($signed(av) < $signed(bv)) ? 32'd1 : 32'd0;
            default: e.res = 32'd0;
        endcase
        e.zero = (e.res == 32'd0);
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string name, input exp_t e);
        check({name, ".res"},  res,             e.res);
        check({name, ".zero"}, 32'(zero),       32'(e.zero));
        check({name, ".cout"}, 32'(carry_out),  32'(e.cout));
        check({name, ".ovf"},  32'(overflow),   32'(e.ovf));
    endtask

    // Drive one operation, let the next edge capture it, then score it
    task automatic apply(input string name, input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv);
        a        = av;
        b        = bv;
        alu_ctrl = op;
        sb.push_back(model(op, av, bv));
        @(posedge clk);
        #1;
        checks++;
        assert (sb.size() > 0) else begin
            failures++;
            $error("FAIL %s.scoreboard observed=empty expected=entry", name);
        end
        if (sb.size() > 0) check_outputs(name, sb.pop_front());
    endtask

    // Independent hand-computed expectations for selected plan vectors
    task automatic apply_k(input string name, input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                           input logic [31:0] kres, input logic kz, input logic kc, input logic kv);
        apply(name, op, av, bv);
        check({name, ".k_res"},  res,            kres);
        check({name, ".k_zero"}, 32'(zero),      32'(kz));
        check({name, ".k_cout"}, 32'(carry_out), 32'(kc));
        check({name, ".k_ovf"},  32'(overflow),  32'(kv));
    endtask

    localparam exp_t RST_VAL = '{res: 32'd0, zero: 1'b1, cout: 1'b0, ovf: 1'b0};

    initial begin
        logic [3:0] ops [8];
        ops[0] = OP_AND;  ops[1] = OP_OR;  ops[2] = OP_ADD; ops[3] = OP_SUB;
        ops[4] = OP_SLT;  ops[5] = OP_XNOR; ops[6] = 4'b1111; ops[7] = 4'b0011;

        rst = 1'b1; a = 32'd0; b = 32'd0; alu_ctrl = 4'd0;
        @(posedge clk); @(posedge clk); #1;
        check_outputs("reset_hold", RST_VAL);
        rst = 1'b0;

        apply("pre_add", OP_ADD, 32'd5, 32'd7);

        // Mid-run async reset: in-flight op is dropped, outputs clear without an edge
        a = 32'h1234_5678; b = 32'h0000_0001; alu_ctrl = OP_ADD;
        #2 rst = 1'b1;
        #1 check_outputs("reset_async", RST_VAL);
        @(posedge clk); #1;
        check_outputs("reset_held", RST_VAL);
        rst = 1'b0;
        #1 check_outputs("reset_release", RST_VAL);

        apply_k("and",  OP_AND,  32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F, 1'b0, 1'b0, 1'b0);
        apply_k("or",   OP_OR,   32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFFF0_0FFF, 1'b0, 1'b0, 1'b0);
        apply_k("xnor", OP_XNOR, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'h0F0F_F0F0, 1'b0, 1'b0, 1'b0);

        apply_k("add_256",   OP_ADD, 32'd256,   32'd256,  32'd512,   1'b0, 1'b0, 1'b0);
        apply_k("add_32768", OP_ADD, 32'd32768, 32'd512,  32'd33280, 1'b0, 1'b0, 1'b0);
        apply_k("add_8902",  OP_ADD, 32'd8902,  32'd0,    32'd8902,  1'b0, 1'b0, 1'b0);
        apply_k("add_4750",  OP_ADD, 32'd0,     32'd4750, 32'd4750,  1'b0, 1'b0, 1'b0);
        apply_k("add_wrap",  OP_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0,    1'b1, 1'b1, 1'b0);
        apply_k("add_ovf",   OP_ADD, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
        apply_k("add_cancel", OP_ADD, 32'h7FFF_FFFF, 32'h8000_0001, 32'd0, 1'b1, 1'b1, 1'b0);

        apply_k("sub_0_4750", OP_SUB, 32'd0,    32'd4750, 32'hFFFF_ED72, 1'b0, 1'b0, 1'b0);
        apply_k("sub_8902_0", OP_SUB, 32'd8902, 32'd0,    32'd8902,      1'b0, 1'b1, 1'b0);
        apply_k("sub_0_0",    OP_SUB, 32'd0,    32'd0,    32'd0,         1'b1, 1'b1, 1'b0);
        apply_k("sub_m50",    OP_SUB, 32'hFFFF_FFCE, 32'hFFFF_FFCE, 32'd0, 1'b1, 1'b1, 1'b0);
        apply_k("sub_ovf",    OP_SUB, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1);

        apply_k("slt_m14_m12", OP_SLT, 32'hFFFF_FFF2, 32'hFFFF_FFF4, 32'd1, 1'b0, 1'b0, 1'b0);
        apply_k("slt_12_10",   OP_SLT, 32'd12, 32'd10, 32'd0, 1'b1, 1'b0, 1'b0);
        apply_k("slt_min_1",   OP_SLT, 32'h8000_0000, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0);
        apply_k("slt_max_m1",  OP_SLT, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0, 1'b0);

        apply_k("undef_f", 4'b1111, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0, 1'b0);
        apply_k("undef_3", 4'b0011, 32'hFFFF_FFFF, 32'd1,         32'd0, 1'b1, 1'b0, 1'b0);

        // Back-to-back random traffic, opcode changes every cycle
        for (int i = 0; i < 60; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = $urandom();
            rb = (i % 5 == 0) ? ra : $urandom();
            apply($sformatf("rnd%0d", i), ops[$urandom_range(0, 7)], ra, rb);
        end

        checks++;
        assert (sb.size() == 0) else begin
            failures++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
